// File: rtl/fpu_rt_sched.sv
// Scheduler for a small pool of iterative sqrt/divide units: dispatches requests to
// free slots, counts down iterations, and arbitrates finished slots onto one writeback port.
module fpu_rt_sched #(
    parameter int unsigned NUNIT  = 3,
    parameter int unsigned STEP_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              except,
    input  logic              req_en,
    input  logic [12:0]       req_op,
    input  logic [9:0]        req_II,
    input  logic [8:0]        req_reg,
    output logic              req_pause,
    output logic [NUNIT-1:0]  disp_en,
    output logic [STEP_W-1:0] disp_steps,
    output logic [2:0]        disp_type,
    output logic              wb_en,
    output logic [NUNIT-1:0]  wb_grant,
    output logic [9:0]        wb_II,
    output logic [8:0]        wb_reg,
    output logic [12:0]       wb_op,
    output logic [NUNIT-1:0]  busy,
    output logic              err_drop
);

    localparam int unsigned PTR_W = (NUNIT > 1) ? $clog2(NUNIT) : 1;

    // Op class encodings carried in req_op[7:0]
    localparam logic [7:0] FOP_SQRT_DL = 8'h20;
    localparam logic [7:0] FOP_SQRT_DH = 8'h21;
    localparam logic [7:0] FOP_DIV_DL  = 8'h22;
    localparam logic [7:0] FOP_DIV_DH  = 8'h23;
    localparam logic [7:0] FOP_SQRT_E  = 8'h24;
    localparam logic [7:0] FOP_DIV_E   = 8'h25;
    localparam logic [7:0] FOP_SQRT_S  = 8'h26;
    localparam logic [7:0] FOP_DIV_S   = 8'h27;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } slot_state_e;

    slot_state_e       state_q [NUNIT];
    slot_state_e       state_d [NUNIT];
    logic [STEP_W-1:0] cnt_q   [NUNIT];
    logic [STEP_W-1:0] cnt_d   [NUNIT];
    logic [9:0]        ii_q    [NUNIT];
    logic [9:0]        ii_d    [NUNIT];
    logic [8:0]        reg_q   [NUNIT];
    logic [8:0]        reg_d   [NUNIT];
    logic [12:0]       op_q    [NUNIT];
    logic [12:0]       op_d    [NUNIT];

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NUNIT-1:0]  disp_en_d, wb_grant_d, busy_d;
    logic [STEP_W-1:0] disp_steps_d;
    logic [2:0]        disp_type_d;
    logic              wb_en_d, err_drop_d;
    logic [9:0]        wb_II_d;
    logic [8:0]        wb_reg_d;
    logic [12:0]       wb_op_d;

    logic              dec_ok;
    logic [STEP_W-1:0] dec_steps;
    logic [2:0]        dec_type;
    logic              free_any, grant_any;
    logic [PTR_W-1:0]  free_idx, gnt_idx;

    // Op decode: iteration count and precision type
    always_comb begin
        dec_ok    = 1'b1;
        dec_steps = '0;
        dec_type  = 3'd0;
        case (req_op[7:0])
            FOP_SQRT_DL, FOP_SQRT_DH, FOP_DIV_DL, FOP_DIV_DH: begin
                dec_steps = STEP_W'(13);
                dec_type  = 3'd0;
            end
            FOP_SQRT_E, FOP_DIV_E: begin
                dec_steps = STEP_W'(16);
                dec_type  = 3'd1;
            end
            FOP_SQRT_S, FOP_DIV_S: begin
                dec_steps = STEP_W'(6);
                dec_type  = 3'd2;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // Lowest-index idle slot from registered state, so a slot freed this edge is not reused
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int k = 0; k < int'(NUNIT); k++) begin
            if (!free_any && state_q[k] == S_IDLE) begin
                free_any = 1'b1;
                free_idx = PTR_W'(k);
            end
        end
    end

    // Round-robin search over DONE slots starting at the pointer
    always_comb begin
        int idx;
        grant_any = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int i = 0; i < int'(NUNIT); i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= int'(NUNIT)) begin
                idx = idx - int'(NUNIT);
            end
            if (!grant_any && state_q[PTR_W'(idx)] == S_DONE) begin
                grant_any = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

    assign req_pause = ~free_any;

    // Next-state: countdown, writeback grant, dispatch, flush
    always_comb begin
        for (int k = 0; k < int'(NUNIT); k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            ii_d[k]    = ii_q[k];
            reg_d[k]   = reg_q[k];
            op_d[k]    = op_q[k];
        end
        ptr_d        = ptr_q;
        disp_en_d    = '0;
        disp_steps_d = disp_steps;
        disp_type_d  = disp_type;
        wb_en_d      = 1'b0;
        wb_grant_d   = '0;
        wb_II_d      = '0;
        wb_reg_d     = '0;
        wb_op_d      = '0;
        err_drop_d   = 1'b0;
        busy_d       = '0;

        if (except) begin
            for (int k = 0; k < int'(NUNIT); k++) begin
                state_d[k] = S_IDLE;
                cnt_d[k]   = '0;
            end
        end else begin
            for (int k = 0; k < int'(NUNIT); k++) begin
                if (state_q[k] == S_RUN) begin
                    if (cnt_q[k] == STEP_W'(1)) begin
                        state_d[k] = S_DONE;
                        cnt_d[k]   = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] - STEP_W'(1);
                    end
                end
            end

            if (grant_any) begin
                wb_en_d = 1'b1;
                ptr_d   = (gnt_idx == PTR_W'(NUNIT - 1)) ? '0 : gnt_idx + PTR_W'(1);
                for (int k = 0; k < int'(NUNIT); k++) begin
                    if (PTR_W'(k) == gnt_idx) begin
                        wb_grant_d[k] = 1'b1;
                        wb_II_d       = ii_q[k];
                        wb_reg_d      = reg_q[k];
                        wb_op_d       = op_q[k];
                        state_d[k]    = S_IDLE;
                    end
                end
            end

            if (req_en && dec_ok) begin
                if (free_any) begin
                    disp_steps_d = dec_steps;
                    disp_type_d  = dec_type;
                    for (int k = 0; k < int'(NUNIT); k++) begin
                        if (PTR_W'(k) == free_idx) begin
                            state_d[k]   = S_RUN;
                            cnt_d[k]     = dec_steps;
                            ii_d[k]      = req_II;
                            reg_d[k]     = req_reg;
                            op_d[k]      = req_op;
                            disp_en_d[k] = 1'b1;
                        end
                    end
                end else begin
                    err_drop_d = 1'b1;
                end
            end
        end

        for (int k = 0; k < int'(NUNIT); k++) begin
            busy_d[k] = (state_d[k] != S_IDLE);
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(NUNIT); k++) begin
                state_q[k] <= S_IDLE;
                cnt_q[k]   <= '0;
                ii_q[k]    <= '0;
                reg_q[k]   <= '0;
                op_q[k]    <= '0;
            end
            ptr_q      <= '0;
            disp_en    <= '0;
            disp_steps <= '0;
            disp_type  <= '0;
            wb_en      <= 1'b0;
            wb_grant   <= '0;
            wb_II      <= '0;
            wb_reg     <= '0;
            wb_op      <= '0;
            busy       <= '0;
            err_drop   <= 1'b0;
        end else begin
            for (int k = 0; k < int'(NUNIT); k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                ii_q[k]    <= ii_d[k];
                reg_q[k]   <= reg_d[k];
                op_q[k]    <= op_d[k];
            end
            ptr_q      <= ptr_d;
            disp_en    <= disp_en_d;
            disp_steps <= disp_steps_d;
            disp_type  <= disp_type_d;
            wb_en      <= wb_en_d;
            wb_grant   <= wb_grant_d;
            wb_II      <= wb_II_d;
            wb_reg     <= wb_reg_d;
            wb_op      <= wb_op_d;
            busy       <= busy_d;
            err_drop   <= err_drop_d;
        end
    end

endmodule

// File: tb/tb_fpu_rt_sched.sv
// Directed bench for fpu_rt_sched: dispatch, countdown latency, round-robin writeback,
// drop on full, flush and asynchronous reset.
module tb_fpu_rt_sched;

    localparam logic [12:0] OP_SQRT_DL = 13'h020;
    localparam logic [12:0] OP_SQRT_DH = 13'h021;
    localparam logic [12:0] OP_DIV_DL  = 13'h022;
    localparam logic [12:0] OP_DIV_DH  = 13'h023;
    localparam logic [12:0] OP_DIV_E   = 13'h025;
    localparam logic [12:0] OP_SQRT_S  = 13'h026;
    localparam logic [12:0] OP_DIV_S   = 13'h027;
    localparam logic [12:0] OP_BAD     = 13'h005;

    logic        clk = 1'b0;
    logic        rst;
    logic        except;
    logic        req_en;
    logic [12:0] req_op;
    logic [9:0]  req_II;
    logic [8:0]  req_reg;
    logic        req_pause;
    logic [2:0]  disp_en;
    logic [4:0]  disp_steps;
    logic [2:0]  disp_type;
    logic        wb_en;
    logic [2:0]  wb_grant;
    logic [9:0]  wb_II;
    logic [8:0]  wb_reg;
    logic [12:0] wb_op;
    logic [2:0]  busy;
    logic        err_drop;

    int total = 0;
    int bad   = 0;
    int wb_seen;

    always #5 clk = ~clk;

    fpu_rt_sched #(.NUNIT(3), .STEP_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .except     (except),
        .req_en     (req_en),
        .req_op     (req_op),
        .req_II     (req_II),
        .req_reg    (req_reg),
        .req_pause  (req_pause),
        .disp_en    (disp_en),
        .disp_steps (disp_steps),
        .disp_type  (disp_type),
        .wb_en      (wb_en),
        .wb_grant   (wb_grant),
        .wb_II      (wb_II),
        .wb_reg     (wb_reg),
        .wb_op      (wb_op),
        .busy       (busy),
        .err_drop   (err_drop)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [12:0] op, input logic [9:0] ii, input logic [8:0] rg);
        req_en  = 1'b1;
        req_op  = op;
        req_II  = ii;
        req_reg = rg;
        step();
        req_en  = 1'b0;
        req_op  = '0;
        req_II  = '0;
        req_reg = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic idle_count_wb(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (wb_en) wb_seen++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; except = 1'b0; req_en = 1'b0;
        req_op = '0; req_II = '0; req_reg = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_disp_en", 32'(disp_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wb_en", 32'(wb_en), 32'h0);
        chk("rst_pause", 32'(req_pause), 32'h0);
        chk("rst_err", 32'(err_drop), 32'h0);
        chk("rst_steps", 32'(disp_steps), 32'h0);
        rst = 1'b0;
        step();

        // Staggered starts that all reach DONE on the same edge
        send(OP_DIV_E, 10'd11, 9'd21);
        chk("a_disp0", 32'(disp_en), 32'h1);
        chk("a_steps0", 32'(disp_steps), 32'd16);
        chk("a_type0", 32'(disp_type), 32'd1);
        idle(2);
        send(OP_DIV_DL, 10'd12, 9'd22);
        chk("a_disp1", 32'(disp_en), 32'h2);
        chk("a_steps1", 32'(disp_steps), 32'd13);
        chk("a_type1", 32'(disp_type), 32'd0);
        idle(6);
        send(OP_DIV_S, 10'd13, 9'd23);
        chk("a_disp2", 32'(disp_en), 32'h4);
        chk("a_steps2", 32'(disp_steps), 32'd6);
        chk("a_type2", 32'(disp_type), 32'd2);
        chk("a_busy_full", 32'(busy), 32'h7);
        chk("a_pause", 32'(req_pause), 32'h1);
        send(OP_DIV_S, 10'd14, 9'd24);
        chk("a_drop", 32'(err_drop), 32'h1);
        chk("a_drop_nodisp", 32'(disp_en), 32'h0);
        chk("a_steps_hold", 32'(disp_steps), 32'd6);
        step();
        chk("a_drop_pulse", 32'(err_drop), 32'h0);
        idle(4);
        chk("a_no_wb_yet", 32'(wb_en), 32'h0);
        send(OP_SQRT_S, 10'd15, 9'd25);
        chk("a_wb_en0", 32'(wb_en), 32'h1);
        chk("a_grant0", 32'(wb_grant), 32'h1);
        chk("a_wb_ii0", 32'(wb_II), 32'd11);
        chk("a_wb_reg0", 32'(wb_reg), 32'd21);
        chk("a_wb_op0", 32'(wb_op), 32'(OP_DIV_E));
        chk("a_no_reuse_drop", 32'(err_drop), 32'h1);
        chk("a_no_reuse_disp", 32'(disp_en), 32'h0);
        step();
        chk("a_grant1", 32'(wb_grant), 32'h2);
        chk("a_wb_ii1", 32'(wb_II), 32'd12);
        chk("a_busy1", 32'(busy), 32'h4);
        step();
        chk("a_grant2", 32'(wb_grant), 32'h4);
        chk("a_wb_ii2", 32'(wb_II), 32'd13);
        chk("a_wb_op2", 32'(wb_op), 32'(OP_DIV_S));
        chk("a_busy2", 32'(busy), 32'h0);
        step();
        chk("a_wb_off", 32'(wb_en), 32'h0);
        chk("a_grant_off", 32'(wb_grant), 32'h0);
        chk("a_wb_ii_off", 32'(wb_II), 32'h0);
        chk("a_pause_off", 32'(req_pause), 32'h0);

        // Single-precision sqrt latency: dispatch in cycle 1, writeback in cycle 8
        send(OP_SQRT_S, 10'd5, 9'd9);
        chk("b_disp", 32'(disp_en), 32'h1);
        chk("b_steps", 32'(disp_steps), 32'd6);
        chk("b_type", 32'(disp_type), 32'd2);
        chk("b_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("b_wait_wb", 32'(wb_en), 32'h0);
            if (i == 1) chk("b_disp_clear", 32'(disp_en), 32'h0);
        end
        step();
        chk("b_wb_en", 32'(wb_en), 32'h1);
        chk("b_grant", 32'(wb_grant), 32'h1);
        chk("b_wb_ii", 32'(wb_II), 32'd5);
        chk("b_wb_reg", 32'(wb_reg), 32'd9);
        chk("b_wb_op", 32'(wb_op), 32'(OP_SQRT_S));
        step();
        chk("b_wb_off", 32'(wb_en), 32'h0);
        chk("b_busy_off", 32'(busy), 32'h0);

        // Pointer now at slot 1: simultaneous DONE on slots 0/1 grants slot 1 first
        send(OP_DIV_E, 10'd30, 9'd1);
        idle(9);
        send(OP_SQRT_S, 10'd31, 9'd2);
        chk("c_disp1", 32'(disp_en), 32'h2);
        idle(6);
        step();
        chk("c_grant_first", 32'(wb_grant), 32'h2);
        chk("c_wb_ii_first", 32'(wb_II), 32'd31);
        step();
        chk("c_grant_second", 32'(wb_grant), 32'h1);
        chk("c_wb_ii_second", 32'(wb_II), 32'd30);
        step();
        chk("c_wb_off", 32'(wb_en), 32'h0);

        // Fill all slots with doubles, drop the fourth, then flush
        send(OP_SQRT_DL, 10'd40, 9'd3);
        chk("d_disp0", 32'(disp_en), 32'h1);
        send(OP_SQRT_DH, 10'd41, 9'd4);
        chk("d_disp1", 32'(disp_en), 32'h2);
        send(OP_DIV_DH, 10'd42, 9'd5);
        chk("d_disp2", 32'(disp_en), 32'h4);
        chk("d_pause", 32'(req_pause), 32'h1);
        send(OP_DIV_DL, 10'd43, 9'd6);
        chk("d_drop", 32'(err_drop), 32'h1);
        chk("d_drop_nodisp", 32'(disp_en), 32'h0);
        except = 1'b1;
        send(OP_SQRT_S, 10'd44, 9'd7);
        except = 1'b0;
        chk("d_flush_busy", 32'(busy), 32'h0);
        chk("d_flush_disp", 32'(disp_en), 32'h0);
        chk("d_flush_err", 32'(err_drop), 32'h0);
        chk("d_flush_pause", 32'(req_pause), 32'h0);
        wb_seen = 0;
        idle_count_wb(20);
        chk("d_no_wb_after_flush", 32'(wb_seen), 32'h0);
        send(OP_SQRT_S, 10'd50, 9'd7);
        chk("d_redisp", 32'(disp_en), 32'h1);
        idle(6);
        step();
        chk("d_wb_ii", 32'(wb_II), 32'd50);
        chk("d_wb_grant", 32'(wb_grant), 32'h1);
        step();

        // Unsupported op, then asynchronous reset mid-run
        send(OP_DIV_DH, 10'd60, 9'd8);
        chk("e_disp", 32'(disp_en), 32'h1);
        send(OP_BAD, 10'd61, 9'd9);
        chk("e_bad_disp", 32'(disp_en), 32'h0);
        chk("e_bad_err", 32'(err_drop), 32'h0);
        chk("e_bad_busy", 32'(busy), 32'h1);
        idle(2);
        #3 rst = 1'b1;
        #1;
        chk("e_rst_busy", 32'(busy), 32'h0);
        chk("e_rst_steps", 32'(disp_steps), 32'h0);
        chk("e_rst_type", 32'(disp_type), 32'h0);
        chk("e_rst_wb", 32'(wb_en), 32'h0);
        chk("e_rst_pause", 32'(req_pause), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        wb_seen = 0;
        idle_count_wb(20);
        chk("e_no_wb_after_rst", 32'(wb_seen), 32'h0);
        send(OP_SQRT_S, 10'd70, 9'd10);
        chk("e_redisp", 32'(disp_en), 32'h1);
        chk("e_rebusy", 32'(busy), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
